// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Gated frequency counter. Counts synchronized rising edges of sig_in over a
// window of GATE cin cycles and publishes the count. While en stays high the
// windows run back to back: the publishing cycle of one window is also the
// first cycle of the next, so every cin cycle belongs to exactly one window.
//
// Parameters
//   GATE  window length in cin cycles (GATE >= 2)
//   CW    width of the edge counter and of freq
//
// Ports
//   cin     in   sole clock, rising edge
//   resetn  in   synchronous active-low reset
//   en      in   measurement enable, level sensitive
//   sig_in  in   measured signal, asynchronous to cin
//   freq    out  edge count of the last completed window
//   valid   out  one-cycle pulse when freq/ovf are updated
//   ovf     out  last completed window saturated the edge counter
//   busy    out  FSM is not in IDLE
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | counters held at zero, edges ignored, waiting for en
// MEASURE | gate_cnt advancing every cycle, edges accumulated
// DONE    | window closed; result registered, next window already counting
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int GATE = 50000000,
    parameter int CW   = 32
) (
    input  logic          cin,
    input  logic          resetn,
    input  logic          en,
    input  logic          sig_in,
    output logic [CW-1:0] freq,
    output logic          valid,
    output logic          ovf,
    output logic          busy
);

    localparam int            GW        = $clog2(GATE);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
    localparam logic [CW-1:0] EDGE_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state_q;
    logic          s1_q;
    logic          s2_q;
    logic          s3_q;
    logic          edge_det;
    logic [GW-1:0] gate_cnt_q;
    logic [CW-1:0] edge_cnt_q;
    logic          sat_q;
    logic [CW-1:0] edge_cnt_d;
    logic          sat_d;
    logic [CW-1:0] freq_q;
    logic          valid_q;
    logic          ovf_q;

    // s1/s2 resolve metastability; s3 is the history bit for edge detection.
    always_ff @(posedge cin) begin
        if (!resetn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~s3_q;

    // Saturating accumulate: the counter sticks at all-ones and any further
    // edge is remembered in sat so the window can be flagged as overflowed.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        if (edge_det) begin
            if (edge_cnt_q == EDGE_MAX) begin
                sat_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge cin) begin
        if (!resetn) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    if (en) begin
                        state_q <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (!en) begin
                        // Abort: partial window is discarded, result untouched.
                        state_q    <= IDLE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        edge_cnt_q <= edge_cnt_d;
                        sat_q      <= sat_d;
                        if (gate_cnt_q == GATE_LAST) begin
                            state_q <= DONE;
                        end else begin
                            gate_cnt_q <= gate_cnt_q + GW'(1);
                        end
                    end
                end

                DONE: begin
                    freq_q  <= edge_cnt_q;
                    ovf_q   <= sat_q;
                    valid_q <= 1'b1;
                    sat_q   <= 1'b0;
                    if (en) begin
                        // This cycle is slot 0 of the next window, so its edge
                        // belongs there and the gate count resumes at 1.
                        state_q    <= MEASURE;
                        gate_cnt_q <= GW'(1);
                        edge_cnt_q <= edge_det ? CW'(1) : '0;
                    end else begin
                        state_q    <= IDLE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                end
            endcase
        end
    end

    assign freq  = freq_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL provide parameter GATE, default 50000000, meaning the gate window length in cin cycles; legal range is GATE >= 2.
REQ-002 SHALL provide parameter CW, default 32, meaning the width of the edge counter and the result.
REQ-003 SHALL provide port cin, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL provide port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide port en, input, 1 bit: measurement enable, synchronous to cin, level-sensitive.
REQ-006 SHALL provide port sig_in, input, 1 bit: the signal under measurement, asynchronous to cin.
REQ-007 SHALL provide port freq, output, CW bits: the rising-edge count of the last completed window, registered.
REQ-008 SHALL provide port valid, output, 1 bit: a one-cycle pulse marking a freq update.
REQ-009 SHALL provide port ovf, output, 1 bit: set when the last completed window saturated, updated together with freq.
REQ-010 SHALL provide port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL pass sig_in through a two-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-012 SHALL define edge = s2 & ~s3, so edge is asserted in exactly one cycle per synchronized rising transition.
REQ-013 SHALL implement an FSM with states IDLE, MEASURE and DONE; the binary encoding is free.
REQ-014 In IDLE, SHALL hold gate_cnt = 0 and edge_cnt = 0, ignore edges, and move to MEASURE in the next cycle when en = 1.
REQ-015 In MEASURE, SHALL increment gate_cnt every cycle and increment edge_cnt in every cycle where edge = 1.
REQ-016 SHALL leave MEASURE for DONE when gate_cnt == GATE-1 in that cycle, counting any edge in that final cycle.
REQ-017 In DONE, SHALL register freq <= edge_cnt, ovf <= sat, and valid <= 1; these take effect for exactly one cycle after DONE.
REQ-018 From DONE with en = 1, SHALL re-enter MEASURE with gate_cnt = 1 and edge_cnt = edge ? 1 : 0, so that back-to-back windows are exactly GATE cycles and no edge is lost or counted twice.
REQ-019 From DONE with en = 0, SHALL return to IDLE with both counters cleared, and the result of the finished window SHALL still be published.
REQ-020 If en = 0 during MEASURE, SHALL abort to IDLE in the next cycle, clear the counters, keep freq and ovf unchanged, and not pulse valid.
REQ-021 edge_cnt SHALL saturate at 2^CW-1 without wrapping; an edge arriving at saturation SHALL set an internal sticky flag sat, which is cleared at the start of each window.
REQ-022 gate_cnt width SHALL be ceil(log2(GATE)) bits minimum, and gate_cnt SHALL never exceed GATE-1.
REQ-023 The window from the first MEASURE cycle to the freq update SHALL be GATE+1 cycles; at GATE=50000000, freq reads directly in Hz for a 50 MHz cin.
REQ-024 valid SHALL be 0 in every cycle other than the one following DONE.

Reset
REQ-025 When resetn = 0 at a cin rising edge, SHALL force state = IDLE; gate_cnt, edge_cnt, sat, s1, s2, s3 = 0; freq = 0; valid = 0; ovf = 0.
REQ-026 Reset asserted mid-window SHALL discard the partial count with no valid pulse.
REQ-027 After resetn returns to 1, the first window SHALL start only via IDLE with en = 1.

Verification
REQ-028 (GATE=10, CW=32) With en = 1 and sig_in toggling every cin cycle (one edge per 2 cycles) in steady state, the bench SHALL check that each valid pulse carries freq = 5 and ovf = 0, and that valid pulses are spaced exactly 10 cycles apart.
REQ-029 (GATE=10) With sig_in held high from before en rises, the bench SHALL check that the first window reports freq = 1 if the synchronized edge falls inside it (else 0), and that every later window reports freq = 0.
REQ-030 (GATE=20, CW=3) With one edge per 2 cycles, the bench SHALL check freq = 7 and ovf = 1; after slowing to one edge per 10 cycles, the next window SHALL give freq = 2 and ovf = 0.
REQ-031 (GATE=10) With en dropped at gate_cnt = 5, the bench SHALL check that busy falls the next cycle, valid stays 0, and freq keeps its prior value.
REQ-032 (GATE=10) With resetn pulsed low for 1 cycle at gate_cnt = 7, the bench SHALL check freq = 0, valid = 0, ovf = 0 and busy = 0 after the edge, and that the next result appears GATE+1 cycles after MEASURE re-entry.
REQ-033 (GATE=10) With a single edge placed in the DONE cycle, the bench SHALL check that it is counted in the following window only.
